seg7_count_display: RTL and testbench

Display stage downstream of `binary_counter`. It takes the counter's binary value, converts it to BCD with a multi-cycle shift-and-add-3 (double-dabble) engine, and drives a time-multiplexed multi-digit seven-segment display. Conversion and display scanning run independently, so a free-running counter never produces a torn or partially converted digit set.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/seg7_count_display.sv | 101 ++++++++++
 tb/tb_seg7_count_display.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment encodings (active-low {g,f,e,d,c,b,a}) and conversion FSM state codes.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: capture, CNT_W shift-and-add-3 cycles, one commit cycle.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int NIB   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   bin_in,
    output logic [4*NIB-1:0]   bcd_out,
    output logic               bcd_valid,
    output logic               busy
);

    localparam int CW = $clog2(CNT_W + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] bin_q;
    logic [4*NIB-1:0] acc;
    logic [4*NIB-1:0] acc_adj;
    logic [CW-1:0]    cnt;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < NIB; i++)
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            bin_q <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bin_q <= bin_in;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    acc   <= {acc_adj[4*NIB-2:0], bin_q[CNT_W-1]};
                    bin_q <= bin_q << 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(CNT_W - 1))
                        state <= ST_COMMIT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bcd_out   = acc;
    assign bcd_valid = (state == ST_COMMIT);
    assign busy      = (state != ST_IDLE);

endmodule

// File: rtl/seg7_count_display.sv
// Counter display stage: BCD conversion feeding a scanned, active-low multi-digit 7-seg display.
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int LZB         = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              blank,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy
);

    // Enough nibbles for the full count range, and never fewer than the display width.
    localparam int NB_CNT = (CNT_W + 2) / 3;
    localparam int NIB    = (NB_CNT > DIGITS) ? NB_CNT : DIGITS;
    localparam int PW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*NIB-1:0]       bcd;
    logic                   bcd_valid;
    logic [DIGITS-1:0][3:0] dig;
    logic                   ovf;
    logic [PW-1:0]          pre;
    logic [IW-1:0]          idx;
    logic [DIGITS-1:0]      lead0;
    logic                   zrun;
    logic [3:0]             cur_d;
    logic                   cur_lz;

    bin2bcd_seq #(.CNT_W(CNT_W), .NIB(NIB)) u_conv (
        .clk       (clk),
        .reset     (reset),
        .bin_in    (count_in),
        .bcd_out   (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    // Digits change only on commit, so the scan never sees a half-converted value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig <= '0;
            ovf <= 1'b0;
        end else if (bcd_valid) begin
            ovf <= |(bcd >> (4 * DIGITS));
            if (~|(bcd >> (4 * DIGITS)))
                dig <= bcd[4*DIGITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(REFRESH_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_comb begin
        lead0 = '0;
        zrun  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zrun     = zrun && (dig[i] == 4'd0);
            lead0[i] = zrun;
        end
    end

    always_comb begin
        cur_d  = '0;
        cur_lz = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (idx == IW'(i)) begin
                cur_d  = dig[i];
                cur_lz = lead0[i];
            end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else if (blank || (LZB != 0 && !ovf && cur_lz)) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= ovf ? SEG_DASH : seg_enc(cur_d);
        end
    end

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display with REFRESH_DIV=4 (2-digit and 1-digit overflow builds).
module tb_seg7_count_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       blank = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic [3:0] count_in1 = 4'd0;
    logic [6:0] seg, seg1;
    logic [1:0] an;
    logic [0:0] an1;
    logic       busy, busy1;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    logic [3:0] samp [0:255];

    localparam logic [6:0] ENC [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    seg7_count_display #(.CNT_W(4), .DIGITS(2), .REFRESH_DIV(4), .LZB(1)) u_dut (
        .clk(clk), .reset(reset), .count_in(count_in), .blank(blank),
        .seg(seg), .an(an), .busy(busy)
    );

    seg7_count_display #(.CNT_W(4), .DIGITS(1), .REFRESH_DIV(4), .LZB(1)) u_dut1 (
        .clk(clk), .reset(reset), .count_in(count_in1), .blank(1'b0),
        .seg(seg1), .an(an1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // samp[k] holds the count_in value present at rising edge k since reset release
    task automatic tick;
        samp[(ecnt + 1) & 255] = count_in;
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    initial begin
        int c, v, ix;
        logic [1:0] ea;
        logic [6:0] es;

        count_in  = 4'd9;
        count_in1 = 4'd12;
        #2 reset = 1'b0;
        repeat (3) begin
            tick;
            chk("rst_an", an, 2'b11);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_busy", busy, 1'b0);
            chk("rst_an1", an1, 1'b1);
        end

        // value 9
        reset = 1'b1;
        ecnt  = 0;
        chk("busy_idle", busy, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k <= 6) chk($sformatf("busy9_k%0d", k), busy, (k <= 5));
            if (k <= 4) begin
                chk($sformatf("an9_k%0d", k), an, 2'b10);
                chk($sformatf("seg9_k%0d", k), seg, 7'b1000000);
            end else if (k <= 8) begin
                chk($sformatf("an9_k%0d", k), an, 2'b11);
                chk($sformatf("seg9_k%0d", k), seg, 7'h7F);
            end else begin
                chk($sformatf("an9_k%0d", k), an, 2'b10);
                chk($sformatf("seg9_k%0d", k), seg, 7'b0010000);
            end
        end
        chk("ovf_an1", an1, 1'b0);
        chk("ovf_seg1", seg1, 7'b0111111);

        // value 15: captured at edge 13, committed at 18
        count_in = 4'd15;
        for (int k = 13; k <= 32; k++) begin
            tick;
            if (k >= 21) begin
                ix = ((k - 1) / 4) % 2;
                chk($sformatf("an15_k%0d", k), an, (ix == 1) ? 2'b01 : 2'b10);
                chk($sformatf("seg15_k%0d", k), seg, (ix == 1) ? 7'b1111001 : 7'b0010010);
            end
        end

        // edge 31 captured 15, edge 32 was the first shift: now in the 2nd SHIFT cycle
        reset = 1'b0;
        #1;
        chk("midrst_an", an, 2'b11);
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_busy", busy, 1'b0);
        tick;
        reset = 1'b1;
        ecnt  = 0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk($sformatf("post_an_k%0d", k), an, 2'b10);
            chk($sformatf("post_seg_k%0d", k), seg, 7'b1000000);
        end

        // running counter with a 6-cycle blank window
        for (int k = 5; k <= 60; k++) begin
            if (k >= 12) count_in = count_in + 4'd1;
            blank = (k >= 30 && k <= 35);
            tick;
            if (k >= 7) begin
                c  = ((k - 7) / 6) * 6 + 1;
                v  = int'(samp[c]);
                ix = ((k - 1) / 4) % 2;
                if (blank || (ix == 1 && v < 10)) begin
                    ea = 2'b11;
                    es = 7'h7F;
                end else begin
                    ea = (ix == 1) ? 2'b01 : 2'b10;
                    es = (ix == 1) ? ENC[v / 10] : ENC[v % 10];
                end
                chk($sformatf("run_an_k%0d", k), an, ea);
                chk($sformatf("run_seg_k%0d", k), seg, es);
            end
        end
        blank = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
